// File: rtl/decode_queue.sv
// Buffered MIPS field decoder: a valid/ready FIFO feeding a registered decode stage.
// An empty FIFO with a free output stage lets a word bypass straight into the output register.
module decode_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  input  logic [XLEN-1:0]         in_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [5:0]              op,
  output logic [4:0]              rs,
  output logic [4:0]              rt,
  output logic [4:0]              rd,
  output logic [4:0]              shamt,
  output logic [5:0]              func,
  output logic [15:0]             imm16,
  output logic [XLEN-1:0]         imm_ext,
  output logic [25:0]             target,
  output logic [2:0]              cp0r_sel,
  output logic                    is_branch,
  output logic                    is_jump,
  output logic                    is_cp0,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]     mem_instr [DEPTH];
  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [31:0]     instr_q;

  logic            load;
  logic            pop;
  logic            bypass;
  logic            push;
  logic [31:0]     src_instr;
  logic [XLEN-1:0] src_pc;
  logic [5:0]      src_op;
  logic [5:0]      src_func;

  // Immediate extension chosen by opcode: logical ops zero-extend, lui shifts up.
  function automatic logic [XLEN-1:0] ext_imm(input logic [31:0] w);
    logic [XLEN-1:0] r;
    r = {{(XLEN-16){w[15]}}, w[15:0]};
    case (w[31:26])
      6'h0C, 6'h0D, 6'h0E: r = XLEN'(w[15:0]);
      6'h0F:               r = XLEN'({w[15:0], 16'h0000});
      default:             ;
    endcase
    return r;
  endfunction

  always_comb begin
    load      = !out_valid || out_ready;
    pop       = load && (count != '0);
    bypass    = load && (count == '0) && in_valid;
    push      = in_valid && in_ready && !bypass;
    src_instr = pop ? mem_instr[rd_ptr] : in_instr;
    src_pc    = pop ? mem_pc[rd_ptr] : in_pc;
    src_op    = src_instr[31:26];
    src_func  = src_instr[5:0];
  end

  assign in_ready = (count < CW'(DEPTH));

  // Storage array carries no reset; occupancy is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_instr[wr_ptr] <= in_instr;
      mem_pc[wr_ptr]    <= in_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      instr_q   <= '0;
      out_pc    <= '0;
      imm_ext   <= '0;
      is_branch <= 1'b0;
      is_jump   <= 1'b0;
      is_cp0    <= 1'b0;
    end else if (flush) begin
      // Flush empties the queue and the output stage; field values are left as they were.
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (load) begin
        out_valid <= pop || bypass;
        if (pop || bypass) begin
          instr_q   <= src_instr;
          out_pc    <= src_pc;
          imm_ext   <= ext_imm(src_instr);
          is_branch <= src_op inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07};
          is_jump   <= (src_op inside {6'h02, 6'h03}) ||
                       ((src_op == 6'h00) && (src_func inside {6'h08, 6'h09}));
          is_cp0    <= (src_op == 6'h10);
        end
      end
    end
  end

  assign op       = instr_q[31:26];
  assign rs       = instr_q[25:21];
  assign rt       = instr_q[20:16];
  assign rd       = instr_q[15:11];
  assign shamt    = instr_q[10:6];
  assign func     = instr_q[5:0];
  assign imm16    = instr_q[15:0];
  assign target   = instr_q[25:0];
  assign cp0r_sel = instr_q[2:0];

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: stimulus queues expected records, a monitor
// compares each record as the consumer takes it.
module tb_decode_queue;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [5:0]      op;
  logic [4:0]      rs, rt, rd, shamt;
  logic [5:0]      func;
  logic [15:0]     imm16;
  logic [XLEN-1:0] imm_ext;
  logic [25:0]     target;
  logic [2:0]      cp0r_sel;
  logic            is_branch, is_jump, is_cp0;
  logic [2:0]      count;

  decode_queue #(.DEPTH(4), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .func(func),
    .imm16(imm16), .imm_ext(imm_ext), .target(target), .cp0r_sel(cp0r_sel),
    .is_branch(is_branch), .is_jump(is_jump), .is_cp0(is_cp0), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        br;
    logic        jmp;
    logic        cp0;
  } rec_t;

  rec_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: a record is consumed when out_valid && out_ready at the next edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'(out_pc), 32'hFFFF_FFFF);
      end else begin
        rec_t e;
        e = sb.pop_front();
        check("out_pc",    out_pc,             e.pc);
        check("op",        32'(op),            32'(e.instr[31:26]));
        check("rs",        32'(rs),            32'(e.instr[25:21]));
        check("rt",        32'(rt),            32'(e.instr[20:16]));
        check("rd",        32'(rd),            32'(e.instr[15:11]));
        check("shamt",     32'(shamt),         32'(e.instr[10:6]));
        check("func",      32'(func),          32'(e.instr[5:0]));
        check("imm16",     32'(imm16),         32'(e.instr[15:0]));
        check("target",    32'(target),        32'(e.instr[25:0]));
        check("cp0r_sel",  32'(cp0r_sel),      32'(e.instr[2:0]));
        check("imm_ext",   imm_ext,            e.imm);
        check("is_branch", 32'(is_branch),     32'(e.br));
        check("is_jump",   32'(is_jump),       32'(e.jmp));
        check("is_cp0",    32'(is_cp0),        32'(e.cp0));
      end
    end
  end

  // Hand-decoded vectors: {instr, imm_ext, branch, jump, cp0}
  logic [31:0] v_instr [11] = '{32'h20080005, 32'h3C01FFFF, 32'h3421FFFF, 32'h2421FFFF,
                                32'h1000FFFF, 32'h0C100000, 32'h03E00008, 32'h40096000,
                                32'h8C820004, 32'h00851020, 32'h2008FFFE};
  logic [31:0] v_imm   [11] = '{32'h00000005, 32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF,
                                32'hFFFFFFFF, 32'h00000000, 32'h00000008, 32'h00006000,
                                32'h00000004, 32'h00001020, 32'hFFFFFFFE};
  logic        v_br    [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
  logic        v_jmp   [11] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
  logic        v_cp0   [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};

  // Offer vector idx until accepted (bounded); expected record queued on acceptance.
  task automatic push_vec(input int idx, input logic [31:0] pc);
    rec_t e;
    int   n;
    in_valid = 1'b1;
    in_instr = v_instr[idx];
    in_pc    = pc;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check("push_timeout", 32'(n), 32'd0);
    end else begin
      e.instr = v_instr[idx]; e.pc = pc; e.imm = v_imm[idx];
      e.br = v_br[idx]; e.jmp = v_jmp[idx]; e.cp0 = v_cp0[idx];
      sb.push_back(e);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count",     32'(count),     32'd0);
    check("rst_out_pc",    out_pc,         32'd0);
    check("rst_imm_ext",   imm_ext,        32'd0);
    check("rst_op",        32'(op),        32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single word through an empty queue reaches the outputs one cycle later.
    push_vec(0, 32'hBFC00000);
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_op",        32'(op),        32'h08);
    check("t1_rt",        32'(rt),        32'h08);
    check("t1_imm_ext",   imm_ext,        32'h00000005);
    check("t1_count",     32'(count),     32'd0);
    @(posedge clk); #1;
    check("t1_drained",   32'(out_valid), 32'd0);

    // Back-pressure: five words, first in output register, four queued.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_vec(i + 1, 32'h1000 + 32'(i * 4));
    check("t2_count_full", 32'(count),     32'd4);
    check("t2_in_ready",   32'(in_ready),  32'd0);
    check("t2_out_valid",  32'(out_valid), 32'd1);
    check("t2_held_op",    32'(op),        32'h0F);
    in_valid = 1'b1; in_instr = v_instr[6]; in_pc = 32'hDEAD0000;
    repeat (2) @(posedge clk); #1;
    check("t2_refused_count", 32'(count), 32'd4);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("t2_drain_valid", 32'(out_valid), 32'd1);
      check("t2_drain_count", 32'(count),     32'(3 - i));
    end
    @(posedge clk); #1;
    check("t2_drain_done", 32'(out_valid), 32'd0);

    // Back-to-back decode of the remaining vectors.
    for (int i = 6; i < 11; i++) push_vec(i, 32'h2000 + 32'(i * 4));
    repeat (2) @(posedge clk); #1;

    // Flush with three queued words and a valid output; offered word must vanish.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_vec(i, 32'h3000 + 32'(i * 4));
    check("t5_count3",    32'(count),     32'd3);
    check("t5_out_valid", 32'(out_valid), 32'd1);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h2408BEEF; in_pc = 32'hBAD00000;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    check("t5_count",     32'(count),     32'd0);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_in_ready",  32'(in_ready),  32'd1);
    out_ready = 1'b1;
    push_vec(7, 32'h4000);
    check("t5_post_valid", 32'(out_valid), 32'd1);
    repeat (3) @(posedge clk); #1;

    // Asynchronous reset between edges mid-burst.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_vec(i + 8, 32'h5000 + 32'(i * 4));
    check("t6_pre_count", 32'(count), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_count", 32'(count),     32'd0);
    sb.delete();
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    push_vec(4, 32'h6000);
    check("t6_post_valid", 32'(out_valid), 32'd1);
    check("t6_post_count", 32'(count),     32'd0);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("sb_empty", 32'(sb.size()), 32'd0);
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
